// File: rtl/const_loader_if.sv
// Request and instruction-stream bundle for the constant loader.
// Each channel uses valid/ready: a transfer happens on a rising edge where both valid and
// ready are high; once valid is raised, the payload and valid hold until that edge.
interface const_loader_if;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_value;
    logic [4:0]  req_rd;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [2:0]  ext_ctrl;
    logic        instr_last;
    logic        busy;

    modport master (
        output req_valid, req_value, req_rd, instr_ready,
        input  req_ready, instr_valid, instr, ext_ctrl, instr_last, busy
    );

    modport slave (
        input  req_valid, req_value, req_rd, instr_ready,
        output req_ready, instr_valid, instr, ext_ctrl, instr_last, busy
    );
endinterface

// File: rtl/const_loader.sv
// Expands a 64-bit constant into a MOVZ followed by ascending-halfword MOVKs for one register,
// one instruction per handshake, with the halfword index exported to the sign extender.
module const_loader #(
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic               CLK,
    input  logic               resetl,
    const_loader_if.slave      bus,
    output logic [1:0]         state_dbg,
    output logic [2:0]         emit_cnt_dbg
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1
    } state_e;

    localparam logic [8:0] OP_MOVZ = 9'b110100101;
    localparam logic [8:0] OP_MOVK = 9'b111100101;

    state_e      state_q, state_d;
    logic [63:0] value_q, value_d;
    logic [4:0]  rd_q, rd_d;
    logic [1:0]  hw_q, hw_d;
    logic        first_q, first_d;
    logic [2:0]  cnt_q, cnt_d;

    logic [1:0]  start_hw;
    logic [1:0]  next_hw;
    logic        has_next;
    logic [15:0] cur_imm;

    // Lowest nonzero halfword of the incoming constant; an all-zero value starts (and ends) at hw 0.
    always_comb begin
        start_hw = 2'd0;
        if (SKIP_ZERO) begin
            for (int i = 3; i >= 0; i--) begin
                if (bus.req_value[16*i +: 16] != 16'h0) begin
                    start_hw = 2'(i);
                end
            end
        end
    end

    always_comb begin
        has_next = 1'b0;
        next_hw  = hw_q;
        for (int i = 3; i >= 0; i--) begin
            if ((i > int'(hw_q)) && (!SKIP_ZERO || (value_q[16*i +: 16] != 16'h0))) begin
                has_next = 1'b1;
                next_hw  = 2'(i);
            end
        end
    end

    assign cur_imm = value_q[{hw_q, 4'b0000} +: 16];

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q <= IDLE;
            value_q <= 64'h0;
            rd_q    <= 5'h0;
            hw_q    <= 2'd0;
            first_q <= 1'b0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            rd_q    <= rd_d;
            hw_q    <= hw_d;
            first_q <= first_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        rd_d    = rd_q;
        hw_d    = hw_q;
        first_d = first_q;
        cnt_d   = cnt_q;

        bus.req_ready   = 1'b0;
        bus.busy        = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = 32'h0;
        bus.ext_ctrl    = 3'b000;
        bus.instr_last  = 1'b0;

        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    value_d = bus.req_value;
                    rd_d    = bus.req_rd;
                    hw_d    = start_hw;
                    first_d = 1'b1;
                    cnt_d   = 3'd1;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                bus.busy        = 1'b1;
                bus.instr_valid = 1'b1;
                bus.instr       = {first_q ? OP_MOVZ : OP_MOVK, hw_q, cur_imm, rd_q};
                bus.ext_ctrl    = {1'b1, hw_q};
                bus.instr_last  = !has_next;
                if (bus.instr_ready) begin
                    if (has_next) begin
                        hw_d    = next_hw;
                        first_d = 1'b0;
                        cnt_d   = cnt_q + 3'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign state_dbg    = state_q;
    assign emit_cnt_dbg = cnt_q;

    // A sequence never exceeds four instructions, and a stalled instruction does not move.
    assert property (@(posedge CLK) disable iff (!resetl)
        (state_q == EMIT) |-> (cnt_q >= 3'd1 && cnt_q <= 3'd4));
    assert property (@(posedge CLK) disable iff (!resetl)
        (bus.instr_valid && !bus.instr_ready) |=> (bus.instr_valid && $stable(bus.instr)
            && $stable(bus.ext_ctrl) && $stable(bus.instr_last)));
endmodule

// File: tb/tb_const_loader.sv
// Scoreboard bench for const_loader: one instance with zero-halfword skipping, one without.
module tb_const_loader;
    logic CLK;
    logic resetl;
    logic [1:0] state_dbg_a, state_dbg_b;
    logic [2:0] cnt_dbg_a, cnt_dbg_b;

    const_loader_if a_if();
    const_loader_if b_if();

    const_loader #(.SKIP_ZERO(1'b1)) dut_a (
        .CLK(CLK), .resetl(resetl), .bus(a_if),
        .state_dbg(state_dbg_a), .emit_cnt_dbg(cnt_dbg_a)
    );

    const_loader #(.SKIP_ZERO(1'b0)) dut_b (
        .CLK(CLK), .resetl(resetl), .bus(b_if),
        .state_dbg(state_dbg_b), .emit_cnt_dbg(cnt_dbg_b)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // entry = {instr[31:0], ext_ctrl[2:0], instr_last}
    logic [35:0] exp_q_a[$];
    logic [35:0] exp_q_b[$];
    logic [35:0] held[2];
    bit          stalled[2];

    bit   rnd_a = 1'b0, rnd_b = 1'b0;
    logic rdy_a = 1'b1, rdy_b = 1'b1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // instr_ready drivers
    always @(posedge CLK) begin
        #1;
        a_if.instr_ready = rnd_a ? 1'($urandom_range(0, 1)) : rdy_a;
        b_if.instr_ready = rnd_b ? 1'($urandom_range(0, 1)) : rdy_b;
    end

    // Reference expansion of a constant into the expected instruction stream.
    function automatic void model(input int id, input logic [63:0] v, input logic [4:0] rd);
        int          hws[$];
        logic [8:0]  op;
        logic [1:0]  h;
        logic [35:0] e;
        for (int i = 0; i < 4; i++) begin
            if (id == 1 || v[16*i +: 16] != 16'h0) hws.push_back(i);
        end
        if (hws.size() == 0) hws.push_back(0);
        for (int k = 0; k < hws.size(); k++) begin
            op = (k == 0) ? 9'h1A5 : 9'h1E5;
            h  = 2'(hws[k]);
            e  = {op, h, v[16*hws[k] +: 16], rd, 1'b1, h, (k == hws.size() - 1) ? 1'b1 : 1'b0};
            if (id == 0) exp_q_a.push_back(e);
            else         exp_q_b.push_back(e);
        end
    endfunction

    task automatic mon(input int id, input logic v, input logic r, input logic [35:0] obs);
        logic [35:0] e;
        if (!v) begin
            check("idle_zero", 64'(obs), 64'h0);
        end
        if (stalled[id] && v) check("stall_hold", 64'(obs), 64'(held[id]));
        if (v && r) begin
            if (id == 0 && exp_q_a.size() > 0) begin
                e = exp_q_a.pop_front();
                check("instr_a", 64'(obs), 64'(e));
            end else if (id == 1 && exp_q_b.size() > 0) begin
                e = exp_q_b.pop_front();
                check("instr_b", 64'(obs), 64'(e));
            end else begin
                check("unexpected_instr", 64'(obs), 64'h0);
            end
        end
        stalled[id] = v && !r;
        held[id]    = obs;
    endtask

    // scoreboard monitor
    always @(negedge CLK) begin
        if (resetl) begin
            mon(0, a_if.instr_valid, a_if.instr_ready, {a_if.instr, a_if.ext_ctrl, a_if.instr_last});
            mon(1, b_if.instr_valid, b_if.instr_ready, {b_if.instr, b_if.ext_ctrl, b_if.instr_last});
        end else begin
            stalled[0] = 1'b0;
            stalled[1] = 1'b0;
        end
    end

    // driver: present a request, wait for acceptance, then scramble the payload
    task automatic send(input int id, input logic [63:0] val, input logic [4:0] rd);
        int n = 0;
        model(id, val, rd);
        @(posedge CLK);
        #1;
        if (id == 0) begin
            a_if.req_valid = 1'b1; a_if.req_value = val; a_if.req_rd = rd;
        end else begin
            b_if.req_valid = 1'b1; b_if.req_value = val; b_if.req_rd = rd;
        end
        forever begin
            @(negedge CLK);
            if ((id == 0 ? a_if.req_ready : b_if.req_ready) || n >= 100) break;
            n++;
        end
        check("accept_timeout", 64'(n >= 100), 64'h0);
        @(posedge CLK);
        #1;
        if (id == 0) begin
            a_if.req_valid = 1'b0; a_if.req_value = ~val; a_if.req_rd = ~rd;
        end else begin
            b_if.req_valid = 1'b0; b_if.req_value = ~val; b_if.req_rd = ~rd;
        end
        @(negedge CLK);
        check("first_valid", 64'(id == 0 ? a_if.instr_valid : b_if.instr_valid), 64'h1);
        check("busy", 64'(id == 0 ? a_if.busy : b_if.busy), 64'h1);
    endtask

    task automatic wait_idle(input int id);
        int n = 0;
        forever begin
            @(negedge CLK);
            if (id == 0 && exp_q_a.size() == 0 && a_if.req_ready) break;
            if (id == 1 && exp_q_b.size() == 0 && b_if.req_ready) break;
            if (n >= 300) break;
            n++;
        end
        check("drain_timeout", 64'(n >= 300), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] v;
        resetl = 1'b0;
        a_if.req_valid = 1'b0; a_if.req_value = 64'h0; a_if.req_rd = 5'h0;
        b_if.req_valid = 1'b0; b_if.req_value = 64'h0; b_if.req_rd = 5'h0;
        #1;
        // reset values, before any clock edge
        check("rst_req_ready", 64'(a_if.req_ready), 64'h1);
        check("rst_instr_valid", 64'(a_if.instr_valid), 64'h0);
        check("rst_outputs", 64'({a_if.instr, a_if.ext_ctrl, a_if.instr_last}), 64'h0);
        check("rst_busy", 64'(a_if.busy), 64'h0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        resetl = 1'b1;

        // zero constant: single MOVZ hw0
        send(0, 64'h0, 5'd3);
        check("zero_instr", 64'(a_if.instr), 64'hD2800003);
        check("zero_ext", 64'(a_if.ext_ctrl), 64'h4);
        check("zero_last", 64'(a_if.instr_last), 64'h1);
        @(negedge CLK);
        check("zero_ready_after", 64'(a_if.req_ready), 64'h1);
        check("zero_valid_after", 64'(a_if.instr_valid), 64'h0);

        // single nonzero halfword at hw1
        send(0, 64'h0000_0000_1234_0000, 5'd1);
        check("hw1_instr", 64'(a_if.instr), 64'hD2A24681);
        check("hw1_ext", 64'(a_if.ext_ctrl), 64'h5);
        wait_idle(0);

        // MOVZ hw0 then MOVK hw3 back to back
        send(0, 64'hFFFF_0000_0000_0001, 5'd2);
        check("two_first", 64'({a_if.instr, a_if.ext_ctrl, a_if.instr_last}), 64'({32'hD2800022, 3'b100, 1'b0}));
        @(negedge CLK);
        check("two_second", 64'({a_if.instr, a_if.ext_ctrl, a_if.instr_last}), 64'({32'hF2FFFFE2, 3'b111, 1'b1}));
        wait_idle(0);

        // same with three cycles of backpressure on the first instruction
        rdy_a = 1'b0;
        send(0, 64'hFFFF_0000_0000_0001, 5'd2);
        repeat (2) begin
            @(negedge CLK);
            check("stall_instr", 64'(a_if.instr), 64'hD2800022);
        end
        rdy_a = 1'b1;
        wait_idle(0);

        // no zero skipping: all four halfwords
        send(1, 64'h1, 5'd0);
        wait_idle(1);
        send(1, 64'h0, 5'd31);
        wait_idle(1);

        // asynchronous reset aborts the sequence after its first handshake
        send(0, 64'hFFFF_0000_0000_0001, 5'd2);
        @(posedge CLK);
        #2;
        resetl = 1'b0;
        #1;
        check("abort_valid", 64'(a_if.instr_valid), 64'h0);
        check("abort_ready", 64'(a_if.req_ready), 64'h1);
        check("abort_outputs", 64'({a_if.instr, a_if.ext_ctrl, a_if.instr_last, a_if.busy}), 64'h0);
        exp_q_a.delete();
        @(negedge CLK);
        check("abort_hold", 64'(a_if.instr_valid), 64'h0);
        resetl = 1'b1;
        // request on the first edge after release
        model(0, 64'h0000_0000_1234_0000, 5'd1);
        a_if.req_valid = 1'b1; a_if.req_value = 64'h0000_0000_1234_0000; a_if.req_rd = 5'd1;
        @(posedge CLK);
        #1;
        a_if.req_valid = 1'b0; a_if.req_value = 64'h0;
        @(negedge CLK);
        check("post_rst_valid", 64'(a_if.instr_valid), 64'h1);
        check("post_rst_instr", 64'(a_if.instr), 64'hD2A24681);
        wait_idle(0);

        // random constants with random backpressure
        rnd_a = 1'b1;
        for (int i = 0; i < 25; i++) begin
            v = 64'h0;
            for (int h = 0; h < 4; h++) begin
                if ($urandom_range(0, 1) == 1) v[16*h +: 16] = 16'($urandom);
            end
            send(0, v, 5'($urandom_range(0, 31)));
        end
        wait_idle(0);
        rnd_a = 1'b0;

        rnd_b = 1'b1;
        for (int i = 0; i < 8; i++) begin
            v = {32'($urandom), 32'($urandom)};
            if (i % 2 == 0) v[31:16] = 16'h0;
            send(1, v, 5'($urandom_range(0, 31)));
        end
        wait_idle(1);
        rnd_b = 1'b0;

        repeat (3) @(negedge CLK);
        check("final_q_a", 64'(exp_q_a.size()), 64'h0);
        check("final_q_b", 64'(exp_q_b.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
